// File: rtl/pipe_flush_ctrl.sv
// Front-end recovery sequencer: picks the oldest mispredict/exception, flushes, drains, redirects fetch.
// Optional FLUSH_PERF_CNT_EN adds flush_count / stall_cycles counters.
//
// state    | meaning
// IDLE     | no recovery in progress
// FLUSH    | one-cycle flush pulse to fetch/decode/issue
// DRAIN    | waiting for in-flight ops and the issue queue to empty
// REDIRECT | restart PC offered to fetch until accepted
module pipe_flush_ctrl #(
  parameter int ADDR         = 32,
  parameter int ROB_DEPTH    = 64,
  parameter int INFLIGHT_MAX = 16,
  localparam int ROB         = $clog2(ROB_DEPTH),
  localparam int CW          = $clog2(INFLIGHT_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            mispred_valid,
  input  logic [ROB-1:0]  mispred_rob_id,
  input  logic [ADDR-1:0] mispred_target,
  input  logic            exc_valid,
  input  logic [ROB-1:0]  exc_rob_id,
  input  logic [ADDR-1:0] exc_vector,
  input  logic [ROB-1:0]  rob_head,
  input  logic            issue_fire,
  input  logic            exe_done,
  input  logic            iq_empty,
  output logic            flush,
  output logic            stall,
  output logic            redirect_valid,
  output logic [ADDR-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
`ifdef FLUSH_PERF_CNT_EN
  ,output logic [31:0]    flush_count,
  output logic [31:0]     stall_cycles
`endif
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [CW-1:0] IMAX = CW'(INFLIGHT_MAX);

  logic [1:0]      state_q, state_d;
  logic [ROB-1:0]  lat_id_q, lat_id_d;
  logic [ADDR-1:0] lat_pc_q, lat_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            flush_q, stall_q, rv_q, busy_q;
  logic [ADDR-1:0] rpc_q, rpc_d;

  logic            ev_valid;
  logic [ROB-1:0]  ev_id;
  logic [ADDR-1:0] ev_pc;
  logic [ROB-1:0]  ev_age, lat_age;
  logic            ev_older;
  logic            flush_enter;

  // Ages are measured from the current head so the comparison survives ROB wrap.
  always_comb begin
    ev_valid = exc_valid | mispred_valid;
    ev_id    = exc_valid ? exc_rob_id : mispred_rob_id;
    ev_pc    = exc_valid ? exc_vector : mispred_target;
    ev_age   = ev_id - rob_head;
    lat_age  = lat_id_q - rob_head;
    ev_older = ev_valid && (ev_age < lat_age);
  end

  always_comb begin
    state_d     = state_q;
    lat_id_d    = lat_id_q;
    lat_pc_d    = lat_pc_q;
    flush_enter = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ev_valid) begin
          lat_id_d    = ev_id;
          lat_pc_d    = ev_pc;
          state_d     = S_FLUSH;
          flush_enter = 1'b1;
        end
      end
      default: begin
        if (ev_older) begin
          lat_id_d    = ev_id;
          lat_pc_d    = ev_pc;
          state_d     = S_FLUSH;
          flush_enter = 1'b1;
        end else begin
          case (state_q)
            S_FLUSH:    state_d = S_DRAIN;
            S_DRAIN:    if (inflight_q == '0 && iq_empty) state_d = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !exe_done && inflight_q != IMAX)
      inflight_d = inflight_q + CW'(1);
    else if (exe_done && !issue_fire && inflight_q != '0)
      inflight_d = inflight_q - CW'(1);
  end

  always_comb begin
    rpc_d = rpc_q;
    if (state_d == S_REDIRECT) rpc_d = lat_pc_d;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= S_IDLE;
      lat_id_q   <= '0;
      lat_pc_q   <= '0;
      inflight_q <= '0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      rv_q       <= 1'b0;
      busy_q     <= 1'b0;
      rpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_id_q   <= lat_id_d;
      lat_pc_q   <= lat_pc_d;
      inflight_q <= inflight_d;
      flush_q    <= flush_enter;
      stall_q    <= (state_d != S_IDLE);
      rv_q       <= (state_d == S_REDIRECT);
      busy_q     <= (state_d != S_IDLE);
      rpc_q      <= rpc_d;
    end
  end

  assign flush          = flush_q;
  assign stall          = stall_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign busy           = busy_q;

`ifdef FLUSH_PERF_CNT_EN
  logic [31:0] flush_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (flush_enter) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (stall_q)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush_count  = flush_cnt_q;
  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl; expected restart PCs go through a scoreboard queue
// that a negedge monitor drains on every redirect handshake.
module tb_pipe_flush_ctrl;
  localparam int ADDR = 32;
  localparam int ROBD = 64;
  localparam int ROB  = 6;

  logic            clk = 1'b0;
  logic            reset_;
  logic            mispred_valid, exc_valid;
  logic [ROB-1:0]  mispred_rob_id, exc_rob_id, rob_head;
  logic [ADDR-1:0] mispred_target, exc_vector;
  logic            issue_fire, exe_done, iq_empty;
  logic            flush, stall, redirect_valid, redirect_ready, busy;
  logic [ADDR-1:0] redirect_pc;
`ifdef FLUSH_PERF_CNT_EN
  logic [31:0]     flush_count, stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [ADDR-1:0] exp_q[$];

  pipe_flush_ctrl #(.ADDR(ADDR), .ROB_DEPTH(ROBD), .INFLIGHT_MAX(16)) dut (
    .clk(clk), .reset_(reset_),
    .mispred_valid(mispred_valid), .mispred_rob_id(mispred_rob_id), .mispred_target(mispred_target),
    .exc_valid(exc_valid), .exc_rob_id(exc_rob_id), .exc_vector(exc_vector),
    .rob_head(rob_head), .issue_fire(issue_fire), .exe_done(exe_done), .iq_empty(iq_empty),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
`ifdef FLUSH_PERF_CNT_EN
    , .flush_count(flush_count), .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_mis(input logic [ROB-1:0] id, input logic [ADDR-1:0] pc);
    mispred_valid = 1'b1; mispred_rob_id = id; mispred_target = pc;
  endtask

  task automatic ev_clr();
    mispred_valid = 1'b0; exc_valid = 1'b0;
  endtask

  task automatic wait_redir(input string nm);
    int k = 0;
    while (redirect_valid !== 1'b1 && k < 60) begin tick(); k++; end
    chk(nm, redirect_valid, 1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 60) begin tick(); k++; end
    chk(nm, busy, 0);
  endtask

  // Monitor: every accepted redirect must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_ && redirect_valid && redirect_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_unexpected: got redirect 0x%0h expected none", redirect_pc);
      end else begin
        chk("sb_redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_ = 1'b0;
    ev_clr(); mispred_rob_id = '0; mispred_target = '0; exc_rob_id = '0; exc_vector = '0;
    rob_head = '0; issue_fire = 1'b0; exe_done = 1'b0; iq_empty = 1'b1; redirect_ready = 1'b1;
    repeat (3) tick();
    chk("rst_flush", flush, 0); chk("rst_stall", stall, 0); chk("rst_rv", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 0); chk("rst_busy", busy, 0);
    reset_ = 1'b1;
    tick();

    // Underflow attempt, then minimum-latency recovery.
    exe_done = 1'b1; tick(); exe_done = 1'b0;
    ev_mis(6'd5, 32'h100); exp_q.push_back(32'h100);
    tick(); ev_clr();
    chk("t1_flush", flush, 1); chk("t1_stall", stall, 1); chk("t1_busy", busy, 1);
    tick();
    chk("t1_flush_end", flush, 0); chk("t1_drain_stall", stall, 1); chk("t1_rv_early", redirect_valid, 0);
    tick();
    chk("t1_rv", redirect_valid, 1); chk("t1_pc", redirect_pc, 32'h100);
    tick();
    chk("t1_idle", busy, 0); chk("t1_rv_drop", redirect_valid, 0); chk("t1_stall_drop", stall, 0);

    // Exception beats a simultaneous (even older) mispredict.
    exc_valid = 1'b1; exc_rob_id = 6'd7; exc_vector = 32'h80;
    ev_mis(6'd3, 32'h200); exp_q.push_back(32'h80);
    tick(); ev_clr();
    wait_idle("t2_done");

    // Older event in DRAIN replaces; younger one is dropped.
    rob_head = 6'd8; iq_empty = 1'b0;
    ev_mis(6'd10, 32'h300); tick(); ev_clr(); tick();
    ev_mis(6'd9, 32'h340); exp_q.push_back(32'h340);
    tick(); ev_clr();
    chk("t3_reflush", flush, 1);
    tick();
    ev_mis(6'd12, 32'h380); tick(); ev_clr();
    chk("t3_young_noflush", flush, 0); chk("t3_still_busy", busy, 1);
    iq_empty = 1'b1;
    wait_idle("t3_done");

    // ROB wrap: head 60, id 62 (age 2) is older than id 2 (age 6).
    rob_head = 6'd60; iq_empty = 1'b0;
    ev_mis(6'd2, 32'h400); tick(); ev_clr(); tick();
    ev_mis(6'd62, 32'h440); exp_q.push_back(32'h440);
    tick(); ev_clr();
    chk("t4_wrap_flush", flush, 1);
    iq_empty = 1'b1;
    wait_idle("t4_done");

    // Inflight: 3 issues, one issue+done pair, then drain needs exactly 3 completions.
    rob_head = 6'd0;
    issue_fire = 1'b1; repeat (3) tick();
    exe_done = 1'b1; tick(); issue_fire = 1'b0; exe_done = 1'b0;
    ev_mis(6'd1, 32'h500); exp_q.push_back(32'h500);
    tick(); ev_clr();
    repeat (4) tick();
    chk("t5_hold_drain", busy, 1); chk("t5_no_rv", redirect_valid, 0);
    exe_done = 1'b1; repeat (2) tick(); exe_done = 1'b0;
    repeat (3) tick();
    chk("t5_two_left_one", redirect_valid, 0); chk("t5_two_busy", busy, 1);
    exe_done = 1'b1; tick(); exe_done = 1'b0;
    wait_redir("t5_redirect");
    wait_idle("t5_done");

    // Backpressure: redirect_pc stable while ready is low.
    redirect_ready = 1'b0;
    ev_mis(6'd4, 32'h600); exp_q.push_back(32'h600);
    tick(); ev_clr();
    wait_redir("t6_redirect");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_rv_hold", redirect_valid, 1); chk("t6_pc_hold", redirect_pc, 32'h600);
    end
    redirect_ready = 1'b1;
    tick();
    chk("t6_accept_idle", busy, 0);

    // Async reset mid-DRAIN: outputs clear without a clock edge, no redirect follows.
    iq_empty = 1'b0;
    ev_mis(6'd6, 32'h700); tick(); ev_clr(); tick();
    chk("t7_in_drain", busy, 1);
    #2 reset_ = 1'b0;
    #1;
    chk("t7_busy", busy, 0); chk("t7_stall", stall, 0); chk("t7_flush", flush, 0);
    chk("t7_rv", redirect_valid, 0); chk("t7_pc", redirect_pc, 0);
    tick(); reset_ = 1'b1; iq_empty = 1'b1;
    repeat (5) tick();
    chk("t7_stays_idle", busy, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
